pipelined_control_unit: RTL and testbench

- Successor to the single-cycle control decoder, for the pipelined RV32I core.
- Decodes the 7-bit opcode once per cycle into a control bundle and carries it down a PIPE_DEPTH-stage shift pipeline.
- Presents the EX, MEM and WB slices from their own stages.
- Adds a run FSM (start / halt-drain / done / error) plus stall, bubble and flush handling.

---
 rtl/pipelined_control_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// Purpose: decodes RV32I opcodes into a control bundle carried down a PIPE_DEPTH-stage pipeline under a run/drain/done/error FSM; PERF_COUNT_EN adds counters.
// Latency: EX slice 1 cycle after opcode sample, MEM PIPE_DEPTH-1, WB PIPE_DEPTH cycles.
// Backpressure: enable=0 freezes all state; stall/flush put a bubble into stage 1 while older stages keep advancing.
module pipelined_control_unit #(
    parameter int          PIPE_DEPTH  = 3,
    parameter logic [6:0]  HALT_OPCODE = 7'b1110011
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       enable,
    input  logic       startProcess,
    input  logic [6:0] opCode,
    input  logic       stall,
    input  logic       flush,
    output logic       endProcess,
    output logic       error,
    output logic       busy,
    output logic [1:0] aluSrc1,
    output logic       aluSrc2,
    output logic [1:0] aluOp,
    output logic       jump,
    output logic       jumpReg,
    output logic       branch,
    output logic       memRead,
    output logic       memWrite,
    output logic       memtoReg,
    output logic       regWrite
`ifdef PERF_COUNT_EN
    ,
    output logic [31:0] instrRetired,
    output logic [31:0] bubbleCount
`endif
);

    localparam logic [6:0] OP_LTYPE = 7'b0000011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_STYPE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_BTYPE = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JTYPE = 7'b1101111;

    typedef struct packed {
        logic       valid;
        logic       halt;
        logic [1:0] alu_src1;
        logic       alu_src2;
        logic [1:0] alu_op;
        logic       jump;
        logic       jump_reg;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       memto_reg;
        logic       reg_write;
    } ctrl_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t state_q, state_d;
    ctrl_t  stage_q [1:PIPE_DEPTH];
    ctrl_t  stage_d [1:PIPE_DEPTH];
    ctrl_t  dec_ctrl;
    logic   dec_illegal;
    logic   halt_in_s1, halt_at_wb, take_op, go_error, drain_kill;

    // Opcode decoder; the halt compare comes first so HALT_OPCODE can be any value.
    always_comb begin
        dec_ctrl       = '0;
        dec_ctrl.valid = 1'b1;
        dec_illegal    = 1'b0;
        if (opCode == HALT_OPCODE) begin
            dec_ctrl.halt = 1'b1;
        end else begin
            case (opCode)
                OP_LTYPE: begin
                    dec_ctrl.mem_read  = 1'b1;
                    dec_ctrl.memto_reg = 1'b1;
                    dec_ctrl.reg_write = 1'b1;
                    dec_ctrl.alu_src2  = 1'b1;
                end
                OP_ITYPE: begin
                    dec_ctrl.reg_write = 1'b1;
                    dec_ctrl.alu_src2  = 1'b1;
                    dec_ctrl.alu_op    = 2'b11;
                end
                OP_AUIPC: begin
                    dec_ctrl.reg_write = 1'b1;
                    dec_ctrl.alu_src1  = 2'b01;
                    dec_ctrl.alu_src2  = 1'b1;
                end
                OP_STYPE: begin
                    dec_ctrl.mem_write = 1'b1;
                    dec_ctrl.alu_src2  = 1'b1;
                end
                OP_RTYPE: begin
                    dec_ctrl.reg_write = 1'b1;
                    dec_ctrl.alu_op    = 2'b10;
                end
                OP_LUI: begin
                    dec_ctrl.reg_write = 1'b1;
                    dec_ctrl.alu_src1  = 2'b10;
                    dec_ctrl.alu_src2  = 1'b1;
                end
                OP_BTYPE: begin
                    dec_ctrl.branch = 1'b1;
                    dec_ctrl.alu_op = 2'b01;
                end
                OP_JALR: begin
                    dec_ctrl.jump_reg  = 1'b1;
                    dec_ctrl.reg_write = 1'b1;
                    dec_ctrl.alu_src2  = 1'b1;
                end
                OP_JTYPE: begin
                    dec_ctrl.jump      = 1'b1;
                    dec_ctrl.reg_write = 1'b1;
                    dec_ctrl.alu_src1  = 2'b01;
                    dec_ctrl.alu_src2  = 1'b1;
                end
                default: begin
                    dec_ctrl.valid = 1'b0;
                    dec_illegal    = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        halt_in_s1 = stage_q[1].valid && stage_q[1].halt;
        halt_at_wb = stage_q[PIPE_DEPTH].valid && stage_q[PIPE_DEPTH].halt;
        take_op    = (state_q == ST_RUN) && !flush && !stall;
        go_error   = take_op && dec_illegal;
        drain_kill = (state_q == ST_DRAIN) && flush && halt_in_s1;
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (startProcess) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (take_op && dec_ctrl.halt) state_d = ST_DRAIN;
                else if (go_error)            state_d = ST_ERROR;
            end
            ST_DRAIN: begin
                if (drain_kill)      state_d = ST_RUN;
                else if (halt_at_wb) state_d = ST_DONE;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Stage 1 only accepts a decoded opcode in RUN; a killed halt is replaced as it leaves stage 1.
    always_comb begin
        for (int k = 1; k <= PIPE_DEPTH; k++) begin
            stage_d[k] = '0;
        end
        stage_d[1] = take_op ? dec_ctrl : '0;
        for (int k = 2; k <= PIPE_DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
        end
        if (drain_kill) begin
            stage_d[2] = '0;
        end
        if (go_error || (state_q == ST_ERROR)) begin
            for (int k = 1; k <= PIPE_DEPTH; k++) begin
                stage_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            for (int k = 1; k <= PIPE_DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else if (enable) begin
            for (int k = 1; k <= PIPE_DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    always_comb begin
        busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        error      = (state_q == ST_ERROR);
        endProcess = (state_q == ST_DRAIN) && halt_at_wb;

        aluSrc1  = stage_q[1].valid ? stage_q[1].alu_src1 : 2'b00;
        aluSrc2  = stage_q[1].valid && stage_q[1].alu_src2;
        aluOp    = stage_q[1].valid ? stage_q[1].alu_op : 2'b00;
        jump     = stage_q[1].valid && stage_q[1].jump;
        jumpReg  = stage_q[1].valid && stage_q[1].jump_reg;
        branch   = stage_q[1].valid && stage_q[1].branch;
        memRead  = stage_q[PIPE_DEPTH-1].valid && stage_q[PIPE_DEPTH-1].mem_read;
        memWrite = stage_q[PIPE_DEPTH-1].valid && stage_q[PIPE_DEPTH-1].mem_write;
        memtoReg = stage_q[PIPE_DEPTH].valid && stage_q[PIPE_DEPTH].memto_reg;
        regWrite = stage_q[PIPE_DEPTH].valid && stage_q[PIPE_DEPTH].reg_write;
    end

`ifdef PERF_COUNT_EN
    logic [31:0] retired_q, retired_d;
    logic [31:0] bubble_q, bubble_d;
    logic        cnt_clear, retire_ev, bubble_ev;

    always_comb begin
        cnt_clear = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && startProcess;
        retire_ev = stage_q[PIPE_DEPTH].valid && !stage_q[PIPE_DEPTH].halt;
        bubble_ev = ((state_q == ST_RUN) && !take_op) || (state_q == ST_DRAIN);

        retired_d = retired_q;
        bubble_d  = bubble_q;
        if (cnt_clear) begin
            retired_d = '0;
            bubble_d  = '0;
        end else begin
            if (retire_ev && (retired_q != 32'hFFFF_FFFF)) retired_d = retired_q + 32'd1;
            if (bubble_ev && (bubble_q != 32'hFFFF_FFFF))  bubble_d  = bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            retired_q <= '0;
            bubble_q  <= '0;
        end else if (enable) begin
            retired_q <= retired_d;
            bubble_q  <= bubble_d;
        end
    end

    assign instrRetired = retired_q;
    assign bubbleCount  = bubble_q;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: depth-3 and depth-5 instances share stimulus; expected
// slices are queued per stage when an opcode is driven and compared when they fall due.
`timescale 1ns/1ps
module tb_pipelined_control_unit;

    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_AU   = 7'b0010111;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JR   = 7'b1100111;
    localparam logic [6:0] OP_J    = 7'b1101111;
    localparam logic [6:0] OP_HALT = 7'b1110011;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    logic       clk = 1'b0;
    logic       rstN, enable, startProcess, stall, flush;
    logic [6:0] opCode;

    logic       end3, err3, busy3, src2_3, jump3, jr3, br3, mr3, mw3, m2r3, rw3;
    logic [1:0] src1_3, aluop3;
    logic       end5, err5, busy5, src2_5, jump5, jr5, br5, mr5, mw5, m2r5, rw5;
    logic [1:0] src1_5, aluop5;
`ifdef PERF_COUNT_EN
    logic [31:0] ret3, bub3, ret5, bub5;
`endif

    pipelined_control_unit #(.PIPE_DEPTH(3)) u_dut3 (
        .clk(clk), .rstN(rstN), .enable(enable), .startProcess(startProcess),
        .opCode(opCode), .stall(stall), .flush(flush),
        .endProcess(end3), .error(err3), .busy(busy3),
        .aluSrc1(src1_3), .aluSrc2(src2_3), .aluOp(aluop3),
        .jump(jump3), .jumpReg(jr3), .branch(br3),
        .memRead(mr3), .memWrite(mw3), .memtoReg(m2r3), .regWrite(rw3)
`ifdef PERF_COUNT_EN
        , .instrRetired(ret3), .bubbleCount(bub3)
`endif
    );

    pipelined_control_unit #(.PIPE_DEPTH(5)) u_dut5 (
        .clk(clk), .rstN(rstN), .enable(enable), .startProcess(startProcess),
        .opCode(opCode), .stall(stall), .flush(flush),
        .endProcess(end5), .error(err5), .busy(busy5),
        .aluSrc1(src1_5), .aluSrc2(src2_5), .aluOp(aluop5),
        .jump(jump5), .jumpReg(jr5), .branch(br5),
        .memRead(mr5), .memWrite(mw5), .memtoReg(m2r5), .regWrite(rw5)
`ifdef PERF_COUNT_EN
        , .instrRetired(ret5), .bubbleCount(bub5)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] ex3_obs, ex5_obs;
    logic [1:0] mem3_obs, wb3_obs, mem5_obs, wb5_obs;
    assign ex3_obs  = {src1_3, src2_3, aluop3, jump3, jr3, br3};
    assign ex5_obs  = {src1_5, src2_5, aluop5, jump5, jr5, br5};
    assign mem3_obs = {mr3, mw3};
    assign wb3_obs  = {m2r3, rw3};
    assign mem5_obs = {mr5, mw5};
    assign wb5_obs  = {m2r5, rw5};

    // Control word: {src1[1:0], src2, aluOp[1:0], jump, jumpReg, branch, memRead, memWrite, memtoReg, regWrite}
    typedef struct {
        int          due;
        logic [11:0] c;
    } sb_t;

    sb_t         ex_q[$], mem3_q[$], wb3_q[$], mem5_q[$], wb5_q[$];
    logic [11:0] last_ex, last_mem3, last_wb3, last_mem5, last_wb5;
    int          cyc, n_checks, n_errors, end_due3, end_due5;
    logic        exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Bit 12 marks a legal opcode.
    function automatic logic [12:0] exp_ctrl(input logic [6:0] op);
        case (op)
            OP_L:    return {1'b1, 2'b00, 1'b1, 2'b00, 3'b000, 4'b1011};
            OP_I:    return {1'b1, 2'b00, 1'b1, 2'b11, 3'b000, 4'b0001};
            OP_AU:   return {1'b1, 2'b01, 1'b1, 2'b00, 3'b000, 4'b0001};
            OP_S:    return {1'b1, 2'b00, 1'b1, 2'b00, 3'b000, 4'b0100};
            OP_R:    return {1'b1, 2'b00, 1'b0, 2'b10, 3'b000, 4'b0001};
            OP_LUI:  return {1'b1, 2'b10, 1'b1, 2'b00, 3'b000, 4'b0001};
            OP_B:    return {1'b1, 2'b00, 1'b0, 2'b01, 3'b001, 4'b0000};
            OP_JR:   return {1'b1, 2'b00, 1'b1, 2'b00, 3'b010, 4'b0001};
            OP_J:    return {1'b1, 2'b01, 1'b1, 2'b00, 3'b100, 4'b0001};
            OP_HALT: return {1'b1, 12'h000};
            default: return 13'h0000;
        endcase
    endfunction

    task automatic clear_sb();
        ex_q.delete(); mem3_q.delete(); wb3_q.delete(); mem5_q.delete(); wb5_q.delete();
        last_ex = '0; last_mem3 = '0; last_wb3 = '0; last_mem5 = '0; last_wb5 = '0;
    endtask

    task automatic check_outputs(input logic bz);
        sb_t e;
        if (ex_q.size() > 0 && ex_q[0].due == cyc)     begin e = ex_q.pop_front();   last_ex   = e.c; end
        if (mem3_q.size() > 0 && mem3_q[0].due == cyc) begin e = mem3_q.pop_front(); last_mem3 = e.c; end
        if (wb3_q.size() > 0 && wb3_q[0].due == cyc)   begin e = wb3_q.pop_front();  last_wb3  = e.c; end
        if (mem5_q.size() > 0 && mem5_q[0].due == cyc) begin e = mem5_q.pop_front(); last_mem5 = e.c; end
        if (wb5_q.size() > 0 && wb5_q[0].due == cyc)   begin e = wb5_q.pop_front();  last_wb5  = e.c; end
        chk("ex3",   32'(ex3_obs),  32'(last_ex[11:4]));
        chk("ex5",   32'(ex5_obs),  32'(last_ex[11:4]));
        chk("mem3",  32'(mem3_obs), 32'(last_mem3[3:2]));
        chk("wb3",   32'(wb3_obs),  32'(last_wb3[1:0]));
        chk("mem5",  32'(mem5_obs), 32'(last_mem5[3:2]));
        chk("wb5",   32'(wb5_obs),  32'(last_wb5[1:0]));
        chk("end3",  32'(end3),     32'(cyc == end_due3));
        chk("end5",  32'(end5),     32'(cyc == end_due5));
        chk("busy3", 32'(busy3),    32'(bz || (cyc <= end_due3)));
        chk("busy5", 32'(busy5),    32'(bz || (cyc <= end_due5)));
        chk("err3",  32'(err3),     32'(exp_err));
        chk("err5",  32'(err5),     32'(exp_err));
    endtask

    // rm: FSM is in RUN before this edge; bz: busy expected after the edge outside a drain.
    task automatic step(input logic [6:0] op, input logic st, input logic fl, input logic sp,
                        input logic en, input logic rm, input logic bz);
        logic [12:0] d;
        sb_t         e;
        opCode = op; stall = st; flush = fl; startProcess = sp; enable = en;
        if (en) begin
            d = exp_ctrl(op);
            if (rm && !st && !fl && !d[12]) begin
                clear_sb();
                exp_err = 1'b1;
            end
            e.c   = (rm && !st && !fl) ? d[11:0] : 12'h000;
            e.due = cyc + 1; ex_q.push_back(e);
            e.due = cyc + 2; mem3_q.push_back(e);
            e.due = cyc + 3; wb3_q.push_back(e);
            e.due = cyc + 4; mem5_q.push_back(e);
            e.due = cyc + 5; wb5_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (en) cyc++;
        check_outputs(bz);
    endtask

    task automatic do_reset(input int n);
        rstN = 1'b0; enable = 1'b1; startProcess = 1'b0; stall = 1'b0; flush = 1'b0; opCode = OP_R;
        repeat (n) @(posedge clk);
        #1;
        clear_sb();
        exp_err  = 1'b0;
        end_due3 = -1;
        end_due5 = -1;
        check_outputs(1'b0);
`ifdef PERF_COUNT_EN
        chk("rst_ret3", ret3, 32'd0);
        chk("rst_bub5", bub5, 32'd0);
`endif
        rstN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 1'b0; enable = 1'b1; startProcess = 1'b0; stall = 1'b0; flush = 1'b0; opCode = '0;
        cyc = 0; n_checks = 0; n_errors = 0; end_due3 = -1; end_due5 = -1; exp_err = 1'b0;
        clear_sb();
        do_reset(2);

        // Start, then a mix of instruction types with a two-cycle stall on ITYPE.
        step(OP_R,   0, 0, 1, 1, 0, 1);
        step(OP_R,   0, 0, 0, 1, 1, 1);
        step(OP_L,   0, 0, 0, 1, 1, 1);
        step(OP_S,   0, 0, 0, 1, 1, 1);
        step(OP_I,   1, 0, 0, 1, 1, 1);
        step(OP_I,   1, 0, 0, 1, 1, 1);
        step(OP_I,   0, 0, 0, 1, 1, 1);
        step(OP_AU,  0, 0, 0, 1, 1, 1);
        step(OP_LUI, 0, 0, 0, 1, 1, 1);
`ifdef PERF_COUNT_EN
        chk("bub3", bub3, 32'd2);
        chk("bub5", bub5, 32'd2);
`endif

        // Halt drains; later opcodes, a late flush and a start request are all ignored.
        end_due3 = cyc + 3;
        end_due5 = cyc + 5;
        step(OP_HALT, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 6; i++) begin
            step(OP_J, (i == 3), (i == 1), (i == 1), 1'b1, 1'b0, 1'b0);
        end
`ifdef PERF_COUNT_EN
        chk("ret3", ret3, 32'd6);
        chk("ret5", ret5, 32'd6);
`endif

        // Restart from DONE; branch then a flushed+stalled jump.
        step(OP_R,  0, 0, 1, 1, 0, 1);
`ifdef PERF_COUNT_EN
        chk("clr_ret5", ret5, 32'd0);
        chk("clr_bub3", bub3, 32'd0);
`endif
        step(OP_B,  0, 0, 1, 1, 1, 1);
        step(OP_J,  1, 1, 0, 1, 1, 1);
        step(OP_R,  0, 0, 0, 1, 1, 1);
        step(OP_JR, 0, 0, 0, 1, 1, 1);

        // Halt killed by flush while it sits in stage 1.
        step(OP_HALT, 0, 0, 0, 1, 1, 1);
        step(OP_L,    0, 1, 0, 1, 0, 1);
        step(OP_L,    0, 0, 0, 1, 1, 1);
        step(OP_I,    0, 0, 0, 1, 1, 1);

        // Freeze for three cycles mid-stream.
        repeat (3) step(OP_S, 0, 0, 0, 0, 1, 1);
        step(OP_L, 0, 0, 0, 1, 1, 1);
        step(OP_S, 0, 0, 0, 1, 1, 1);
        repeat (5) step(OP_R, 0, 0, 0, 1, 1, 1);

        // Illegal opcode: error, pipeline cleared, start ignored until reset.
        step(OP_BAD, 0, 0, 0, 1, 1, 0);
        repeat (2) step(OP_R, 0, 0, 1, 1, 0, 0);
        do_reset(1);

        // Reset while endProcess is asserted cancels it.
        step(OP_R, 0, 0, 1, 1, 0, 1);
        step(OP_R, 0, 0, 0, 1, 1, 1);
        end_due3 = cyc + 3;
        end_due5 = cyc + 5;
        step(OP_HALT, 0, 0, 0, 1, 1, 0);
        step(OP_R,    0, 0, 0, 1, 0, 0);
        step(OP_R,    0, 0, 0, 1, 0, 0);
        do_reset(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
